// File: rtl/sram_multi_bank_ring_ctrl.sv
// sram_multi_bank_ring_ctrl
//
// Purpose:
//   Arbitrates one single-port multi-bank SRAM between a producer and a
//   consumer. The banks form a ring of frame buffers. The producer fills one
//   bank per frame. The consumer drains completed frames in the order they
//   were written. At most one SRAM access is issued per cycle. When both
//   sides want the SRAM in the same cycle, the grant alternates between them.
//
// Optional feature:
//   Define SRAM_RING_CTRL_STAT_EN to build a 16-bit saturating counter of
//   arbitration-conflict cycles. When the macro is undefined, cfl_cnt_o is
//   tied to zero.
//
// Ports:
//   clk            : sole clock, rising edge
//   rst            : synchronous active-high reset
//   wr_req_i       : producer has a word
//   wr_dat_i       : producer word
//   wr_lst_i       : word closes the current frame
//   wr_ack_o       : producer word accepted this cycle
//   rd_req_i       : consumer requests the next word
//   rd_ack_o       : read issued to the SRAM this cycle
//   rd_val_o       : rd_dat_o valid
//   rd_dat_o       : read word (straight from the SRAM)
//   rd_lst_o       : last word of a frame, qualifies rd_val_o
//   sram_idx_bnk_o : SRAM bank select
//   sram_adr_o     : SRAM word address
//   sram_wr_val_o  : SRAM byte enables (all ones on a write)
//   sram_wr_dat_o  : SRAM write data
//   sram_rd_val_o  : SRAM read strobe
//   sram_rd_dat_i  : SRAM read data
//   bnk_cnt_o      : number of completed, unread frames
//   cfl_cnt_o      : arbitration-conflict counter

module sram_multi_bank_ring_ctrl #(
    parameter int NUMB_BNK    = 2,
    parameter int SIZE        = 64,
    parameter int SIZE_COL    = 8,
    parameter int DATA_WD     = 32,
    parameter int KNOB_REGOUT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_req_i,
    input  logic [DATA_WD-1:0]            wr_dat_i,
    input  logic                          wr_lst_i,
    output logic                          wr_ack_o,
    input  logic                          rd_req_i,
    output logic                          rd_ack_o,
    output logic                          rd_val_o,
    output logic [DATA_WD-1:0]            rd_dat_o,
    output logic                          rd_lst_o,
    output logic [$clog2(NUMB_BNK)-1:0]   sram_idx_bnk_o,
    output logic [$clog2(SIZE)-1:0]       sram_adr_o,
    output logic [DATA_WD/SIZE_COL-1:0]   sram_wr_val_o,
    output logic [DATA_WD-1:0]            sram_wr_dat_o,
    output logic                          sram_rd_val_o,
    input  logic [DATA_WD-1:0]            sram_rd_dat_i,
    output logic [$clog2(NUMB_BNK):0]     bnk_cnt_o,
    output logic [15:0]                   cfl_cnt_o
);

    localparam int BW  = $clog2(NUMB_BNK);
    localparam int AW  = $clog2(SIZE);
    localparam int CW  = DATA_WD / SIZE_COL;
    localparam int LAT = KNOB_REGOUT + 1;

    localparam logic [AW-1:0] LAST_ADR = AW'(SIZE - 1);
    localparam logic [BW:0]   FULL_CNT = (BW + 1)'(NUMB_BNK);

    typedef enum logic {
        PRI_WR,
        PRI_RD
    } pri_e;

    pri_e              pri_q, pri_d;
    logic [BW-1:0]     wrBnk_q, wrBnk_d;
    logic [AW-1:0]     wrAdr_q, wrAdr_d;
    logic [BW-1:0]     rdBnk_q, rdBnk_d;
    logic [AW-1:0]     rdAdr_q, rdAdr_d;
    logic [AW:0]       len_q [NUMB_BNK];
    logic [AW:0]       len_d [NUMB_BNK];
    logic [BW:0]       bnkCnt_q, bnkCnt_d;
    logic [LAT-1:0]    valPipe_q, valPipe_d;
    logic [LAT-1:0]    lstPipe_q, lstPipe_d;

    logic wrElig, rdElig, conflict;
    logic wrGnt, rdGnt;
    logic wrClose, rdEnd;

    // Eligibility and grant decisions. Reset masks both requests so that no
    // SRAM access and no handshake can appear while rst is high. A frame is
    // readable only after it has been closed and counted in bnkCnt_q, so a
    // partially written frame can never be read.
    always_comb begin
        wrElig   = wr_req_i & ~rst & (bnkCnt_q < FULL_CNT);
        rdElig   = rd_req_i & ~rst & (bnkCnt_q != '0);
        conflict = wrElig & rdElig;
        wrGnt    = wrElig & (~rdElig | (pri_q == PRI_WR));
        rdGnt    = rdElig & (~wrElig | (pri_q == PRI_RD));
        wrClose  = wrGnt & (wr_lst_i | (wrAdr_q == LAST_ADR));
        rdEnd    = rdGnt & ({1'b0, rdAdr_q} == (len_q[rdBnk_q] - 1'b1));
    end

    // Priority FSM. The state changes only on a conflict cycle. On such a
    // cycle the side that was just served loses priority.
    always_comb begin
        pri_d = pri_q;
        if (conflict) begin
            pri_d = (pri_q == PRI_WR) ? PRI_RD : PRI_WR;
        end
    end

    // Pointer, length and frame-count updates. Banks and addresses are powers
    // of two, so a plain increment wraps the ring naturally.
    always_comb begin
        wrBnk_d  = wrBnk_q;
        wrAdr_d  = wrAdr_q;
        rdBnk_d  = rdBnk_q;
        rdAdr_d  = rdAdr_q;
        len_d    = len_q;
        bnkCnt_d = bnkCnt_q;

        if (wrGnt) begin
            if (wrClose) begin
                len_d[wrBnk_q] = {1'b0, wrAdr_q} + 1'b1;
                wrAdr_d        = '0;
                wrBnk_d        = wrBnk_q + 1'b1;
            end else begin
                wrAdr_d = wrAdr_q + 1'b1;
            end
        end

        if (rdGnt) begin
            if (rdEnd) begin
                rdAdr_d = '0;
                rdBnk_d = rdBnk_q + 1'b1;
            end else begin
                rdAdr_d = rdAdr_q + 1'b1;
            end
        end

        // Only one access per cycle, so close and end are exclusive.
        if (wrClose) begin
            bnkCnt_d = bnkCnt_q + 1'b1;
        end else if (rdEnd) begin
            bnkCnt_d = bnkCnt_q - 1'b1;
        end

        // Shift the grant and last flag along the delay line. The delay line
        // is as long as the SRAM read latency.
        valPipe_d = LAT'({valPipe_q, rdGnt});
        lstPipe_d = LAT'({lstPipe_q, rdEnd});
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q     <= PRI_WR;
            wrBnk_q   <= '0;
            wrAdr_q   <= '0;
            rdBnk_q   <= '0;
            rdAdr_q   <= '0;
            bnkCnt_q  <= '0;
            valPipe_q <= '0;
            lstPipe_q <= '0;
            for (int b = 0; b < NUMB_BNK; b++) begin
                len_q[b] <= '0;
            end
        end else begin
            pri_q     <= pri_d;
            wrBnk_q   <= wrBnk_d;
            wrAdr_q   <= wrAdr_d;
            rdBnk_q   <= rdBnk_d;
            rdAdr_q   <= rdAdr_d;
            bnkCnt_q  <= bnkCnt_d;
            valPipe_q <= valPipe_d;
            lstPipe_q <= lstPipe_d;
            len_q     <= len_d;
        end
    end

    // SRAM port mux. When there is no grant, every field is driven to zero.
    always_comb begin
        sram_idx_bnk_o = '0;
        sram_adr_o     = '0;
        sram_wr_val_o  = '0;
        sram_wr_dat_o  = '0;
        sram_rd_val_o  = 1'b0;
        if (wrGnt) begin
            sram_idx_bnk_o = wrBnk_q;
            sram_adr_o     = wrAdr_q;
            sram_wr_val_o  = {CW{1'b1}};
            sram_wr_dat_o  = wr_dat_i;
        end else if (rdGnt) begin
            sram_idx_bnk_o = rdBnk_q;
            sram_adr_o     = rdAdr_q;
            sram_rd_val_o  = 1'b1;
        end
    end

    // Registered status outputs are also forced low while rst is high, so
    // that reset takes effect on the outputs in the same cycle.
    assign wr_ack_o  = wrGnt;
    assign rd_ack_o  = rdGnt;
    assign rd_val_o  = valPipe_q[LAT-1] & ~rst;
    assign rd_lst_o  = lstPipe_q[LAT-1] & ~rst;
    assign rd_dat_o  = sram_rd_dat_i;
    assign bnk_cnt_o = rst ? '0 : bnkCnt_q;

`ifdef SRAM_RING_CTRL_STAT_EN
    logic [15:0] cflCnt_q, cflCnt_d;

    // Saturating count of cycles in which both sides were eligible.
    always_comb begin
        cflCnt_d = cflCnt_q;
        if (conflict && (cflCnt_q != 16'hFFFF)) begin
            cflCnt_d = cflCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cflCnt_q <= '0;
        end else begin
            cflCnt_q <= cflCnt_d;
        end
    end

    assign cfl_cnt_o = rst ? 16'd0 : cflCnt_q;
`else
    assign cfl_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_sram_multi_bank_ring_ctrl.sv
// tb_sram_multi_bank_ring_ctrl
//
// Purpose:
//   Self-checking bench for sram_multi_bank_ring_ctrl with NUMB_BNK=2,
//   SIZE=4, DATA_WD=32 and KNOB_REGOUT=0. A small behavioural SRAM with a
//   1-cycle read latency sits on the SRAM port. The directed scenarios use
//   constant expectations. A randomized run is checked against a frame-level
//   reference model built from queues.
//
// The expected conflict count follows the SRAM_RING_CTRL_STAT_EN macro.

module tb_sram_multi_bank_ring_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req_i;
    logic [31:0] wr_dat_i;
    logic        wr_lst_i;
    logic        wr_ack_o;
    logic        rd_req_i;
    logic        rd_ack_o;
    logic        rd_val_o;
    logic [31:0] rd_dat_o;
    logic        rd_lst_o;
    logic        sram_idx_bnk_o;
    logic [1:0]  sram_adr_o;
    logic [3:0]  sram_wr_val_o;
    logic [31:0] sram_wr_dat_o;
    logic        sram_rd_val_o;
    logic [31:0] sram_rd_dat_i;
    logic [1:0]  bnk_cnt_o;
    logic [15:0] cfl_cnt_o;

    int passCnt  = 0;
    int checkCnt = 0;

`ifdef SRAM_RING_CTRL_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    always #5 clk = ~clk;

    sram_multi_bank_ring_ctrl #(
        .NUMB_BNK   (2),
        .SIZE       (4),
        .SIZE_COL   (8),
        .DATA_WD    (32),
        .KNOB_REGOUT(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req_i      (wr_req_i),
        .wr_dat_i      (wr_dat_i),
        .wr_lst_i      (wr_lst_i),
        .wr_ack_o      (wr_ack_o),
        .rd_req_i      (rd_req_i),
        .rd_ack_o      (rd_ack_o),
        .rd_val_o      (rd_val_o),
        .rd_dat_o      (rd_dat_o),
        .rd_lst_o      (rd_lst_o),
        .sram_idx_bnk_o(sram_idx_bnk_o),
        .sram_adr_o    (sram_adr_o),
        .sram_wr_val_o (sram_wr_val_o),
        .sram_wr_dat_o (sram_wr_dat_o),
        .sram_rd_val_o (sram_rd_val_o),
        .sram_rd_dat_i (sram_rd_dat_i),
        .bnk_cnt_o     (bnk_cnt_o),
        .cfl_cnt_o     (cfl_cnt_o)
    );

    // Behavioural SRAM: 2 banks x 4 words, 1-cycle read latency.
    logic [31:0] mem [0:7];

    always @(posedge clk) begin
        if (sram_wr_val_o == 4'hF) begin
            mem[{sram_idx_bnk_o, sram_adr_o}] <= sram_wr_dat_o;
        end
        if (sram_rd_val_o) begin
            sram_rd_dat_i <= mem[{sram_idx_bnk_o, sram_adr_o}];
        end
    end

    // Drive one cycle's inputs at the falling edge, then let the
    // combinational outputs settle before the caller samples them.
    task automatic applyStimulus(input logic wr, input logic lst,
                                 input logic [31:0] dat, input logic rd);
        @(negedge clk);
        wr_req_i = wr;
        wr_lst_i = lst;
        wr_dat_i = dat;
        rd_req_i = rd;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b1;
        wr_req_i = 1'b0;
        wr_lst_i = 1'b0;
        rd_req_i = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        wr_req_i = 1'b1;
        rd_req_i = 1'b1;
        wr_lst_i = 1'b1;
        wr_dat_i = 32'hDEAD_BEEF;
        #1;
        checkCnt++; if (wr_ack_o !== 1'b0) $display("[TB] FAIL reset_wr_ack: got %0b expected 0", wr_ack_o); else passCnt++;
        checkCnt++; if (rd_ack_o !== 1'b0) $display("[TB] FAIL reset_rd_ack: got %0b expected 0", rd_ack_o); else passCnt++;
        checkCnt++; if (sram_wr_val_o !== 4'h0) $display("[TB] FAIL reset_sram_wr_val: got %h expected 0", sram_wr_val_o); else passCnt++;
        checkCnt++; if (sram_rd_val_o !== 1'b0) $display("[TB] FAIL reset_sram_rd_val: got %0b expected 0", sram_rd_val_o); else passCnt++;
        @(negedge clk);
        #1;
        checkCnt++; if (bnk_cnt_o !== 2'd0) $display("[TB] FAIL reset_bnk_cnt: got %0d expected 0", bnk_cnt_o); else passCnt++;
        checkCnt++; if (rd_val_o !== 1'b0) $display("[TB] FAIL reset_rd_val: got %0b expected 0", rd_val_o); else passCnt++;
        checkCnt++; if (cfl_cnt_o !== 16'd0) $display("[TB] FAIL reset_cfl_cnt: got %0d expected 0", cfl_cnt_o); else passCnt++;
        checkCnt++; if (sram_adr_o !== 2'd0) $display("[TB] FAIL reset_sram_adr: got %0d expected 0", sram_adr_o); else passCnt++;
        @(negedge clk);
        rst      = 1'b0;
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        wr_lst_i = 1'b0;
    endtask

    // A 4-word frame without wr_lst_i closes on the last address. A full
    // ring then blocks writes until the first frame is drained.
    task automatic test_fill_and_full();
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h10 + i, 1'b0);
            checkCnt++; if (wr_ack_o !== 1'b1) $display("[TB] FAIL fill_wr_ack[%0d]: got %0b expected 1", i, wr_ack_o); else passCnt++;
            checkCnt++; if (sram_idx_bnk_o !== 1'b0) $display("[TB] FAIL fill_bank[%0d]: got %0d expected 0", i, sram_idx_bnk_o); else passCnt++;
            checkCnt++; if (sram_adr_o !== 2'(i)) $display("[TB] FAIL fill_adr[%0d]: got %0d expected %0d", i, sram_adr_o, i); else passCnt++;
            checkCnt++; if (sram_wr_val_o !== 4'hF) $display("[TB] FAIL fill_wr_val[%0d]: got %h expected f", i, sram_wr_val_o); else passCnt++;
            checkCnt++; if (sram_wr_dat_o !== 32'h10 + i) $display("[TB] FAIL fill_wr_dat[%0d]: got %h expected %h", i, sram_wr_dat_o, 32'h10 + i); else passCnt++;
        end
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b0);
        checkCnt++; if (bnk_cnt_o !== 2'd1) $display("[TB] FAIL fill_bnk_cnt_1: got %0d expected 1", bnk_cnt_o); else passCnt++;
        checkCnt++; if (sram_idx_bnk_o !== 1'b1) $display("[TB] FAIL fill_second_bank: got %0d expected 1", sram_idx_bnk_o); else passCnt++;
        checkCnt++; if (sram_adr_o !== 2'd0) $display("[TB] FAIL fill_second_adr: got %0d expected 0", sram_adr_o); else passCnt++;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h21, 1'b0);
            checkCnt++; if (bnk_cnt_o !== 2'd2) $display("[TB] FAIL full_bnk_cnt[%0d]: got %0d expected 2", i, bnk_cnt_o); else passCnt++;
            checkCnt++; if (wr_ack_o !== 1'b0) $display("[TB] FAIL full_wr_blocked[%0d]: got %0b expected 0", i, wr_ack_o); else passCnt++;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h55, 1'b1);
            checkCnt++; if (rd_ack_o !== 1'b1) $display("[TB] FAIL drain_rd_ack[%0d]: got %0b expected 1", i, rd_ack_o); else passCnt++;
            checkCnt++; if (wr_ack_o !== 1'b0) $display("[TB] FAIL drain_wr_ack[%0d]: got %0b expected 0", i, wr_ack_o); else passCnt++;
            checkCnt++; if (sram_rd_val_o !== 1'b1) $display("[TB] FAIL drain_sram_rd_val[%0d]: got %0b expected 1", i, sram_rd_val_o); else passCnt++;
            checkCnt++; if (sram_wr_val_o !== 4'h0) $display("[TB] FAIL drain_sram_wr_val[%0d]: got %h expected 0", i, sram_wr_val_o); else passCnt++;
            checkCnt++; if (sram_idx_bnk_o !== 1'b0) $display("[TB] FAIL drain_bank[%0d]: got %0d expected 0", i, sram_idx_bnk_o); else passCnt++;
            checkCnt++; if (sram_adr_o !== 2'(i)) $display("[TB] FAIL drain_adr[%0d]: got %0d expected %0d", i, sram_adr_o, i); else passCnt++;
            if (i > 0) begin
                checkCnt++; if (rd_val_o !== 1'b1) $display("[TB] FAIL drain_rd_val[%0d]: got %0b expected 1", i, rd_val_o); else passCnt++;
                checkCnt++; if (rd_dat_o !== 32'h10 + i - 1) $display("[TB] FAIL drain_rd_dat[%0d]: got %h expected %h", i, rd_dat_o, 32'h10 + i - 1); else passCnt++;
                checkCnt++; if (rd_lst_o !== 1'b0) $display("[TB] FAIL drain_rd_lst[%0d]: got %0b expected 0", i, rd_lst_o); else passCnt++;
            end
        end
        applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
        checkCnt++; if (wr_ack_o !== 1'b1) $display("[TB] FAIL refill_wr_ack: got %0b expected 1", wr_ack_o); else passCnt++;
        checkCnt++; if (sram_idx_bnk_o !== 1'b0) $display("[TB] FAIL refill_bank: got %0d expected 0", sram_idx_bnk_o); else passCnt++;
        checkCnt++; if (sram_adr_o !== 2'd0) $display("[TB] FAIL refill_adr: got %0d expected 0", sram_adr_o); else passCnt++;
        checkCnt++; if (bnk_cnt_o !== 2'd1) $display("[TB] FAIL refill_bnk_cnt: got %0d expected 1", bnk_cnt_o); else passCnt++;
        checkCnt++; if (rd_val_o !== 1'b1) $display("[TB] FAIL drain_last_val: got %0b expected 1", rd_val_o); else passCnt++;
        checkCnt++; if (rd_dat_o !== 32'h13) $display("[TB] FAIL drain_last_dat: got %h expected 13", rd_dat_o); else passCnt++;
        checkCnt++; if (rd_lst_o !== 1'b1) $display("[TB] FAIL drain_last_lst: got %0b expected 1", rd_lst_o); else passCnt++;
    endtask

    // A 2-word frame closed by wr_lst_i, followed by a read of an empty ring.
    task automatic test_short_frame();
        resetDut();
        applyStimulus(1'b1, 1'b0, 32'hA0, 1'b1);
        checkCnt++; if (rd_ack_o !== 1'b0) $display("[TB] FAIL empty_rd_ack: got %0b expected 0", rd_ack_o); else passCnt++;
        checkCnt++; if (sram_adr_o !== 2'd0) $display("[TB] FAIL short_wr_adr0: got %0d expected 0", sram_adr_o); else passCnt++;
        applyStimulus(1'b1, 1'b1, 32'hA1, 1'b0);
        checkCnt++; if (sram_adr_o !== 2'd1) $display("[TB] FAIL short_wr_adr1: got %0d expected 1", sram_adr_o); else passCnt++;
        checkCnt++; if (bnk_cnt_o !== 2'd0) $display("[TB] FAIL short_partial_unreadable: got %0d expected 0", bnk_cnt_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkCnt++; if (rd_ack_o !== 1'b1) $display("[TB] FAIL short_rd_ack0: got %0b expected 1", rd_ack_o); else passCnt++;
        checkCnt++; if (rd_val_o !== 1'b0) $display("[TB] FAIL short_rd_val_early: got %0b expected 0", rd_val_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkCnt++; if (sram_adr_o !== 2'd1) $display("[TB] FAIL short_rd_adr1: got %0d expected 1", sram_adr_o); else passCnt++;
        checkCnt++; if (rd_val_o !== 1'b1) $display("[TB] FAIL short_rd_val0: got %0b expected 1", rd_val_o); else passCnt++;
        checkCnt++; if (rd_dat_o !== 32'hA0) $display("[TB] FAIL short_rd_dat0: got %h expected a0", rd_dat_o); else passCnt++;
        checkCnt++; if (rd_lst_o !== 1'b0) $display("[TB] FAIL short_rd_lst0: got %0b expected 0", rd_lst_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkCnt++; if (rd_ack_o !== 1'b0) $display("[TB] FAIL short_empty_rd_ack: got %0b expected 0", rd_ack_o); else passCnt++;
        checkCnt++; if (sram_rd_val_o !== 1'b0) $display("[TB] FAIL short_empty_sram_rd: got %0b expected 0", sram_rd_val_o); else passCnt++;
        checkCnt++; if (bnk_cnt_o !== 2'd0) $display("[TB] FAIL short_bnk_cnt: got %0d expected 0", bnk_cnt_o); else passCnt++;
        checkCnt++; if (rd_dat_o !== 32'hA1) $display("[TB] FAIL short_rd_dat1: got %h expected a1", rd_dat_o); else passCnt++;
        checkCnt++; if (rd_lst_o !== 1'b1) $display("[TB] FAIL short_rd_lst1: got %0b expected 1", rd_lst_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkCnt++; if (rd_val_o !== 1'b0) $display("[TB] FAIL short_rd_val_after: got %0b expected 0", rd_val_o); else passCnt++;
    endtask

    // One stored frame plus continuous requests on both sides: the grants
    // alternate W,R,W,R starting with W. The reset that follows lands while
    // a read is in flight.
    task automatic test_alternate_and_reset();
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h40 + i, 1'b0);
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h50 + c, 1'b1);
            checkCnt++; if (wr_ack_o !== ((c % 2) == 0)) $display("[TB] FAIL alt_wr_ack[%0d]: got %0b expected %0b", c, wr_ack_o, (c % 2) == 0); else passCnt++;
            checkCnt++; if (rd_ack_o !== ((c % 2) == 1)) $display("[TB] FAIL alt_rd_ack[%0d]: got %0b expected %0b", c, rd_ack_o, (c % 2) == 1); else passCnt++;
            checkCnt++; if (sram_idx_bnk_o !== ((c % 2) == 0)) $display("[TB] FAIL alt_bank[%0d]: got %0d expected %0d", c, sram_idx_bnk_o, (c % 2) == 0); else passCnt++;
            checkCnt++; if (sram_adr_o !== 2'(c / 2)) $display("[TB] FAIL alt_adr[%0d]: got %0d expected %0d", c, sram_adr_o, c / 2); else passCnt++;
            checkCnt++; if (cfl_cnt_o !== (STAT ? 16'(c) : 16'd0)) $display("[TB] FAIL alt_cfl_cnt[%0d]: got %0d expected %0d", c, cfl_cnt_o, STAT ? c : 0); else passCnt++;
            checkCnt++; if (bnk_cnt_o !== 2'd1) $display("[TB] FAIL alt_bnk_cnt[%0d]: got %0d expected 1", c, bnk_cnt_o); else passCnt++;
            if ((c % 2) == 0 && c > 0) begin
                checkCnt++; if (rd_dat_o !== 32'h40 + c / 2 - 1) $display("[TB] FAIL alt_rd_dat[%0d]: got %h expected %h", c, rd_dat_o, 32'h40 + c / 2 - 1); else passCnt++;
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkCnt++; if (rd_val_o !== 1'b0) $display("[TB] FAIL midrst_rd_val: got %0b expected 0", rd_val_o); else passCnt++;
        checkCnt++; if (wr_ack_o !== 1'b0) $display("[TB] FAIL midrst_wr_ack: got %0b expected 0", wr_ack_o); else passCnt++;
        @(negedge clk);
        rst      = 1'b0;
        wr_req_i = 1'b0;
        rd_req_i = 1'b0;
        #1;
        checkCnt++; if (bnk_cnt_o !== 2'd0) $display("[TB] FAIL midrst_bnk_cnt: got %0d expected 0", bnk_cnt_o); else passCnt++;
        checkCnt++; if (rd_val_o !== 1'b0) $display("[TB] FAIL midrst_rd_val_after: got %0b expected 0", rd_val_o); else passCnt++;
        checkCnt++; if (cfl_cnt_o !== 16'd0) $display("[TB] FAIL midrst_cfl_cnt: got %0d expected 0", cfl_cnt_o); else passCnt++;
        applyStimulus(1'b1, 1'b1, 32'h77, 1'b0);
        checkCnt++; if (wr_ack_o !== 1'b1) $display("[TB] FAIL midrst_wr_ack_after: got %0b expected 1", wr_ack_o); else passCnt++;
        checkCnt++; if (sram_idx_bnk_o !== 1'b0) $display("[TB] FAIL midrst_bank: got %0d expected 0", sram_idx_bnk_o); else passCnt++;
        checkCnt++; if (sram_adr_o !== 2'd0) $display("[TB] FAIL midrst_adr: got %0d expected 0", sram_adr_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkCnt++; if (sram_idx_bnk_o !== 1'b0) $display("[TB] FAIL midrst_rd_bank: got %0d expected 0", sram_idx_bnk_o); else passCnt++;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkCnt++; if (rd_dat_o !== 32'h77) $display("[TB] FAIL midrst_rd_dat: got %h expected 77", rd_dat_o); else passCnt++;
        checkCnt++; if (rd_lst_o !== 1'b1) $display("[TB] FAIL midrst_rd_lst: got %0b expected 1", rd_lst_o); else passCnt++;
    endtask

    // Randomized traffic checked against a frame-level model: a queue of
    // closed-frame lengths, a flat queue of their words and the words of the
    // frame being written. Bank numbers follow from how many frames have
    // been written or read so far.
    task automatic test_random();
        logic [31:0] wordQ[$];
        logic [31:0] partQ[$];
        int          frameLen[$];
        int          wrFrames = 0;
        int          rdFrames = 0;
        int          rdPos    = 0;
        bit          favourRd = 1'b0;
        int          cfl      = 0;
        bit          expVal   = 1'b0;
        bit          expLst   = 1'b0;
        logic [31:0] expDat   = '0;
        resetDut();
        for (int n = 0; n < 3000; n++) begin
            logic        wr, lst, rd, wrE, rdE, gW, gR;
            logic [31:0] dat;
            int          expBnk, expAdr, cnt;
            wr  = ($urandom_range(0, 3) != 0);
            lst = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 2) != 0);
            dat = $urandom;
            applyStimulus(wr, lst, dat, rd);

            cnt = frameLen.size();
            wrE = wr && (cnt < 2);
            rdE = rd && (cnt > 0);
            if (wrE && rdE) begin
                gW       = !favourRd;
                gR       = favourRd;
                favourRd = !favourRd;
            end else begin
                gW = wrE;
                gR = rdE;
            end
            expBnk = gW ? (wrFrames % 2) : (gR ? (rdFrames % 2) : 0);
            expAdr = gW ? partQ.size() : (gR ? rdPos : 0);

            checkCnt++; if (wr_ack_o !== gW) $display("[TB] FAIL rnd_wr_ack@%0d: got %0b expected %0b", n, wr_ack_o, gW); else passCnt++;
            checkCnt++; if (rd_ack_o !== gR) $display("[TB] FAIL rnd_rd_ack@%0d: got %0b expected %0b", n, rd_ack_o, gR); else passCnt++;
            checkCnt++; if (sram_rd_val_o !== gR) $display("[TB] FAIL rnd_sram_rd_val@%0d: got %0b expected %0b", n, sram_rd_val_o, gR); else passCnt++;
            checkCnt++; if (sram_wr_val_o !== (gW ? 4'hF : 4'h0)) $display("[TB] FAIL rnd_sram_wr_val@%0d: got %h expected %h", n, sram_wr_val_o, gW ? 4'hF : 4'h0); else passCnt++;
            checkCnt++; if (sram_idx_bnk_o !== 1'(expBnk)) $display("[TB] FAIL rnd_bank@%0d: got %0d expected %0d", n, sram_idx_bnk_o, expBnk); else passCnt++;
            checkCnt++; if (sram_adr_o !== 2'(expAdr)) $display("[TB] FAIL rnd_adr@%0d: got %0d expected %0d", n, sram_adr_o, expAdr); else passCnt++;
            checkCnt++; if (bnk_cnt_o !== 2'(cnt)) $display("[TB] FAIL rnd_bnk_cnt@%0d: got %0d expected %0d", n, bnk_cnt_o, cnt); else passCnt++;
            checkCnt++; if (cfl_cnt_o !== 16'(STAT ? cfl : 0)) $display("[TB] FAIL rnd_cfl_cnt@%0d: got %0d expected %0d", n, cfl_cnt_o, STAT ? cfl : 0); else passCnt++;
            checkCnt++; if (rd_val_o !== expVal) $display("[TB] FAIL rnd_rd_val@%0d: got %0b expected %0b", n, rd_val_o, expVal); else passCnt++;
            if (gW) begin
                checkCnt++; if (sram_wr_dat_o !== dat) $display("[TB] FAIL rnd_wr_dat@%0d: got %h expected %h", n, sram_wr_dat_o, dat); else passCnt++;
            end
            if (expVal) begin
                checkCnt++; if (rd_dat_o !== expDat) $display("[TB] FAIL rnd_rd_dat@%0d: got %h expected %h", n, rd_dat_o, expDat); else passCnt++;
                checkCnt++; if (rd_lst_o !== expLst) $display("[TB] FAIL rnd_rd_lst@%0d: got %0b expected %0b", n, rd_lst_o, expLst); else passCnt++;
            end

            if (wrE && rdE && cfl < 16'hFFFF) cfl++;
            expVal = gR;
            expLst = 1'b0;
            if (gR) begin
                expDat = wordQ.pop_front();
                rdPos++;
                if (rdPos == frameLen[0]) begin
                    void'(frameLen.pop_front());
                    rdPos  = 0;
                    rdFrames++;
                    expLst = 1'b1;
                end
            end
            if (gW) begin
                partQ.push_back(dat);
                if (lst || partQ.size() == 4) begin
                    frameLen.push_back(partQ.size());
                    foreach (partQ[k]) wordQ.push_back(partQ[k]);
                    partQ.delete();
                    wrFrames++;
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        wr_req_i = 1'b0;
        wr_lst_i = 1'b0;
        wr_dat_i = '0;
        rd_req_i = 1'b0;
        test_reset();
        test_fill_and_full();
        test_short_frame();
        test_alternate_and_reset();
        test_random();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
